// File: rtl/l2_burst_adapter.sv
// Line-to-burst adapter. It takes one full-line read or write from the arbitrated L2 port,
// runs it as BEATS sequential narrow transfers on the memory port, and returns a one-cycle l2_resp.
module l2_burst_adapter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned BEAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l2_read,
    input  logic              l2_write,
    input  logic [ADDR_W-1:0] l2_address,
    input  logic [LINE_W-1:0] l2_wdata,
    output logic [LINE_W-1:0] l2_rdata,
    output logic              l2_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned OFF   = $clog2(LINE_W / 8);
    localparam int unsigned BOFF  = $clog2(BEAT_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e                state;
    logic [CNT_W-1:0]      beat;
    logic [ADDR_W-OFF-1:0] line_addr;
    logic [LINE_W-1:0]     wline;
    logic [LINE_W-1:0]     rline;
    logic [LINE_W-1:0]     rline_next;
    logic                  unused_offset;

    // Offset bits of the request address are dropped; the burst always starts at beat 0.
    assign unused_offset = ^l2_address[OFF-1:0];

    // Read line with the current beat merged in. It is published to l2_rdata only on the
    // last beat, so l2_rdata keeps the previous line until a read actually completes.
    always_comb begin
        rline_next = rline;
        rline_next[beat*BEAT_W +: BEAT_W] = pmem_rdata;
    end

    assign pmem_address = {line_addr, beat, {BOFF{1'b0}}};
    assign pmem_wdata   = wline[beat*BEAT_W +: BEAT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            beat       <= '0;
            line_addr  <= '0;
            wline      <= '0;
            rline      <= '0;
            l2_rdata   <= '0;
            l2_resp    <= 1'b0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            l2_resp <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (l2_write || l2_read) begin
                        line_addr <= l2_address[ADDR_W-1:OFF];
                        wline     <= l2_wdata;
                        beat      <= '0;
                        if (l2_write) begin
                            state      <= StWr;
                            pmem_write <= 1'b1;
                        end else begin
                            state     <= StRd;
                            pmem_read <= 1'b1;
                        end
                    end
                end
                StRd, StWr: begin
                    if (pmem_resp) begin
                        if (state == StRd) begin
                            rline <= rline_next;
                        end
                        if (beat == LAST_BEAT) begin
                            state      <= StDone;
                            pmem_read  <= 1'b0;
                            pmem_write <= 1'b0;
                            l2_resp    <= 1'b1;
                            if (state == StRd) begin
                                l2_rdata <= rline_next;
                            end
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_burst_adapter.sv
// Self-checking bench for l2_burst_adapter: directed vector table, hand sequences for held
// requests and mid-burst reset, then random bursts checked against a word-memory model.
module tb_l2_burst_adapter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int BEAT_W = 32;
    localparam int BEATS  = LINE_W / BEAT_W;

    typedef logic [255:0] w_t;

    typedef struct {
        bit                rd;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        int                wait_beat;
        int                wait_n;
        int                exp_lat;
        logic [LINE_W-1:0] exp_rdata;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              l2_read = 1'b0;
    logic              l2_write = 1'b0;
    logic [ADDR_W-1:0] l2_address = '0;
    logic [LINE_W-1:0] l2_wdata = '0;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [BEAT_W-1:0] mem [16384];
    logic [LINE_W-1:0] last_line = '0;
    bit prev_resp = 1'b0;

    always #5 clk = ~clk;

    l2_burst_adapter #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W),
        .BEAT_W(BEAT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .l2_read     (l2_read),
        .l2_write    (l2_write),
        .l2_address  (l2_address),
        .l2_wdata    (l2_wdata),
        .l2_rdata    (l2_rdata),
        .l2_resp     (l2_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    task automatic chk(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The response pulse must never last two consecutive cycles.
    always @(negedge clk) begin
        if (rst_n && l2_resp) chk("resp_back_to_back", w_t'(prev_resp), w_t'(0));
        prev_resp = rst_n && l2_resp;
    end

    task automatic idle_cycle(input string name);
        @(negedge clk);
        chk(name, w_t'({l2_resp, pmem_read, pmem_write}), w_t'(0));
        chk("idle_rdata_hold", w_t'(l2_rdata), w_t'(last_line));
        pmem_resp  = 1'($urandom_range(0, 1));
        pmem_rdata = $urandom;
    endtask

    // One line transaction against the memory model. Called just after a negedge in an
    // idle cycle; returns at the negedge of the l2_resp cycle.
    task automatic run_txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] wd, input int wait_beat, input int wait_n,
                           input bit hold, output int lat, output logic [LINE_W-1:0] rdata_seen);
        bit                is_rd;
        bit                done;
        int                b;
        int                w;
        int                wi;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] ea;
        logic [LINE_W-1:0] exp_line;
        is_rd = rd && !wr;
        base  = {addr[ADDR_W-1:4], 4'h0};
        for (int i = 0; i < BEATS; i++) begin
            wi = int'(base[ADDR_W-1:2]) + i;
            exp_line[i*BEAT_W +: BEAT_W] = mem[wi];
        end
        l2_read    = rd;
        l2_write   = wr;
        l2_address = addr;
        l2_wdata   = wd;
        b = 0; w = 0; done = 1'b0; lat = 0; rdata_seen = '0;
        for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                l2_address = ADDR_W'($urandom);
                l2_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end
            if (b < BEATS) begin
                ea = base + ADDR_W'(4 * b);
                chk("beat_pmem_read", w_t'(pmem_read), w_t'(is_rd));
                chk("beat_pmem_write", w_t'(pmem_write), w_t'(!is_rd));
                chk("beat_pmem_address", w_t'(pmem_address), w_t'(ea));
                if (!is_rd) chk("beat_pmem_wdata", w_t'(pmem_wdata), w_t'(wd[b*BEAT_W +: BEAT_W]));
                chk("beat_no_l2_resp", w_t'(l2_resp), w_t'(0));
                if (b == wait_beat && w < wait_n) begin
                    pmem_resp  = 1'b0;
                    pmem_rdata = $urandom;
                    w++;
                end else begin
                    pmem_resp = 1'b1;
                    if (is_rd) begin
                        pmem_rdata = mem[ea[ADDR_W-1:2]];
                    end else begin
                        mem[ea[ADDR_W-1:2]] = wd[b*BEAT_W +: BEAT_W];
                        pmem_rdata = $urandom;
                    end
                    b++;
                end
            end else begin
                if (is_rd) last_line = exp_line;
                chk("done_l2_resp", w_t'(l2_resp), w_t'(1));
                chk("done_pmem_idle", w_t'({pmem_read, pmem_write}), w_t'(0));
                chk("done_l2_rdata", w_t'(l2_rdata), w_t'(last_line));
                rdata_seen = l2_rdata;
                lat        = cyc;
                done       = 1'b1;
                pmem_resp  = 1'($urandom_range(0, 1));
                if (!hold) begin
                    l2_read  = 1'b0;
                    l2_write = 1'b0;
                end
            end
        end
        chk("txn_completed", w_t'(done), w_t'(1));
    endtask

    vec_t              vecs[4];
    int                lat;
    logic [LINE_W-1:0] rd_seen;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 16'h1234, '0, 0, 0, 5,
                    128'h44444444_33333333_22222222_11111111};
        vecs[1] = '{1'b0, 1'b1, 16'h0F08, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 2, 3, 8,
                    128'h44444444_33333333_22222222_11111111};
        vecs[2] = '{1'b1, 1'b1, 16'h2040, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 0, 0, 5,
                    128'h44444444_33333333_22222222_11111111};
        vecs[3] = '{1'b1, 1'b0, 16'h0F00, '0, 1, 2, 7,
                    128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA};

        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        for (int i = 0; i < BEATS; i++) mem[(16'h1230 >> 2) + i] = 32'h11111111 * (i + 1);

        // Reset, then idle with stray pmem_resp pulses.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle_outputs", w_t'({l2_rdata, l2_resp, pmem_read, pmem_write,
                                            pmem_address, pmem_wdata}), w_t'(0));
            pmem_resp = 1'($urandom_range(0, 1));
        end

        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wait_beat,
                    vecs[i].wait_n, 1'b0, lat, rd_seen);
            chk("vec_latency", w_t'(lat), w_t'(vecs[i].exp_lat));
            chk("vec_l2_rdata", w_t'(rd_seen), w_t'(vecs[i].exp_rdata));
            idle_cycle("vec_gap_idle");
        end

        // Read held through DONE: no accept in DONE, a new burst from the following idle cycle.
        run_txn(1'b1, 1'b0, 16'h0400, '0, 0, 0, 1'b1, lat, rd_seen);
        chk("held_first_latency", w_t'(lat), w_t'(5));
        @(negedge clk);
        chk("held_no_accept_in_done", w_t'({l2_resp, pmem_read, pmem_write}), w_t'(0));
        run_txn(1'b1, 1'b0, 16'h0400, '0, 0, 0, 1'b0, lat, rd_seen);
        chk("held_second_latency", w_t'(lat), w_t'(5));
        idle_cycle("held_gap_idle");

        // Reset after beat 1 of a read.
        l2_read    = 1'b1;
        l2_address = 16'h3008;
        @(negedge clk);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("midrst_before_read", w_t'(pmem_read), w_t'(1));
        chk("midrst_before_addr", w_t'(pmem_address), w_t'(16'h3008));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pmem_read_drop", w_t'(pmem_read), w_t'(0));
        chk("midrst_outputs_zero", w_t'({l2_rdata, l2_resp, pmem_write}), w_t'(0));
        l2_read   = 1'b0;
        last_line = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) idle_cycle("post_reset_idle");
        run_txn(1'b1, 1'b0, 16'h3008, '0, 0, 0, 1'b0, lat, rd_seen);
        chk("post_reset_latency", w_t'(lat), w_t'(5));
        idle_cycle("post_reset_gap");

        // Random bursts against the memory model.
        for (int n = 0; n < 40; n++) begin
            bit rd;
            bit wr;
            int wb;
            int wn;
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            wb = $urandom_range(0, BEATS - 1);
            wn = $urandom_range(0, 3);
            run_txn(rd, wr, ADDR_W'($urandom), {$urandom, $urandom, $urandom, $urandom},
                    wb, wn, 1'b0, lat, rd_seen);
            chk("rand_latency", w_t'(lat), w_t'(BEATS + 1 + wn));
            repeat ($urandom_range(1, 3)) idle_cycle("rand_gap_idle");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
